// File: rtl/raster_fill_sequencer.sv
// Triangle raster-fill sequencer: clears the frame, then sweeps one triangle at a time and owns pixel write port A.
// Optional bounding-box culling is enabled with `define RASTER_FILL_BBOX_CULL_EN.
module raster_fill_sequencer #(
  parameter int FRAME_WIDTH  = 512,
  parameter int FRAME_HEIGHT = 384,
  parameter int ADDR_BITS    = 18,
  parameter int COLOR_WIDTH  = 16,
  parameter int FILL_LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic [COLOR_WIDTH-1:0] clear_color,
  input  logic                   tri_valid,
  input  logic [COLOR_WIDTH-1:0] tri_color,
  output logic                   tri_ready,
  output logic                   tri_load,
  output logic [15:0]            hcount,
  output logic [15:0]            vcount,
  input  logic                   is_within,
  output logic                   pix_we,
  output logic [ADDR_BITS-1:0]   pix_addr,
  output logic [COLOR_WIDTH-1:0] pix_din,
  output logic                   busy,
  output logic                   tri_done,
`ifdef RASTER_FILL_BBOX_CULL_EN
  input  logic [15:0]            bbox_min_x,
  input  logic [15:0]            bbox_min_y,
  input  logic [15:0]            bbox_max_x,
  input  logic [15:0]            bbox_max_y,
`endif
  output logic [15:0]            tri_count
);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SWEEP, DRAIN} state_t;

  localparam int unsigned          NPIX      = FRAME_WIDTH * FRAME_HEIGHT;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NPIX - 1);
  localparam logic [15:0]          X_MAX     = 16'(FRAME_WIDTH - 1);
  localparam logic [15:0]          Y_MAX     = 16'(FRAME_HEIGHT - 1);
  localparam int                   DW        = (FILL_LATENCY > 1) ? $clog2(FILL_LATENCY) : 1;

  state_t                 state_q;
  logic                   clear_pending_q;
  logic [COLOR_WIDTH-1:0] clear_color_q;
  logic [COLOR_WIDTH-1:0] tri_color_q;
  logic [ADDR_BITS-1:0]   clr_cnt_q;
  logic [15:0]            hcount_q;
  logic [15:0]            vcount_q;
  logic [DW-1:0]          drain_q;
  logic                   tri_ready_q;
  logic                   tri_load_q;
  logic                   tri_done_q;
  logic [15:0]            tri_count_q;

  logic                   accept;
  logic [15:0]            x_lo, x_hi, y_lo, y_hi;
  logic                   box_empty;

  assign accept = (state_q == IDLE) && !clear_pending_q && !frame_start && tri_valid && tri_ready_q;

`ifdef RASTER_FILL_BBOX_CULL_EN
  logic [15:0] x_lo_q, x_hi_q, y_lo_q, y_hi_q;

  function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] m);
    return (v > m) ? m : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      x_lo_q <= '0;
      x_hi_q <= '0;
      y_lo_q <= '0;
      y_hi_q <= '0;
    end else if (accept) begin
      x_lo_q <= clamp(bbox_min_x, X_MAX);
      x_hi_q <= clamp(bbox_max_x, X_MAX);
      y_lo_q <= clamp(bbox_min_y, Y_MAX);
      y_hi_q <= clamp(bbox_max_y, Y_MAX);
    end
  end

  assign x_lo      = x_lo_q;
  assign x_hi      = x_hi_q;
  assign y_lo      = y_lo_q;
  assign y_hi      = y_hi_q;
  assign box_empty = (x_lo_q > x_hi_q) || (y_lo_q > y_hi_q);
`else
  assign x_lo      = 16'd0;
  assign x_hi      = X_MAX;
  assign y_lo      = 16'd0;
  assign y_hi      = Y_MAX;
  assign box_empty = 1'b0;
`endif

  // Tag pipe: stage FILL_LATENCY-1 lines up with is_within for the same coordinate.
  logic                 tag_in_v;
  logic [ADDR_BITS-1:0] tag_in_a;
  logic                 tag_v_q [FILL_LATENCY];
  logic [ADDR_BITS-1:0] tag_a_q [FILL_LATENCY];

  assign tag_in_v = (state_q == SWEEP);
  assign tag_in_a = ADDR_BITS'(vcount_q) * ADDR_BITS'(FRAME_WIDTH) + ADDR_BITS'(hcount_q);

  for (genvar gi = 0; gi < FILL_LATENCY; gi++) begin : g_tag
    always_ff @(posedge clk) begin
      if (rst) begin
        tag_v_q[gi] <= 1'b0;
        tag_a_q[gi] <= '0;
      end else if (gi == 0) begin
        tag_v_q[gi] <= tag_in_v;
        tag_a_q[gi] <= tag_in_a;
      end else begin
        tag_v_q[gi] <= tag_v_q[(gi > 0) ? gi - 1 : 0];
        tag_a_q[gi] <= tag_a_q[(gi > 0) ? gi - 1 : 0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      clear_pending_q <= 1'b0;
      clear_color_q   <= '0;
      tri_color_q     <= '0;
      clr_cnt_q       <= '0;
      hcount_q        <= '0;
      vcount_q        <= '0;
      drain_q         <= '0;
      tri_ready_q     <= 1'b0;
      tri_load_q      <= 1'b0;
      tri_done_q      <= 1'b0;
      tri_count_q     <= '0;
    end else begin
      tri_load_q      <= 1'b0;
      tri_done_q      <= 1'b0;
      clear_pending_q <= clear_pending_q | frame_start;
      case (state_q)
        IDLE: begin
          if (clear_pending_q || frame_start) begin
            state_q         <= CLEAR;
            clear_pending_q <= 1'b0;
            clear_color_q   <= clear_color;
            clr_cnt_q       <= '0;
            tri_ready_q     <= 1'b0;
          end else if (accept) begin
            state_q     <= LOAD;
            tri_color_q <= tri_color;
            tri_load_q  <= 1'b1;
            tri_ready_q <= 1'b0;
          end else begin
            tri_ready_q <= 1'b1;
          end
        end
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_ADDR) begin
            state_q     <= IDLE;
            tri_count_q <= '0;
            tri_ready_q <= !(clear_pending_q || frame_start);
          end
        end
        LOAD: begin
          if (box_empty) begin
            state_q    <= DRAIN;
            drain_q    <= '0;
            tri_done_q <= (FILL_LATENCY == 1);
          end else begin
            state_q  <= SWEEP;
            hcount_q <= x_lo;
            vcount_q <= y_lo;
          end
        end
        SWEEP: begin
          if (hcount_q == x_hi) begin
            if (vcount_q == y_hi) begin
              state_q    <= DRAIN;
              drain_q    <= '0;
              hcount_q   <= '0;
              vcount_q   <= '0;
              tri_done_q <= (FILL_LATENCY == 1);
            end else begin
              hcount_q <= x_lo;
              vcount_q <= vcount_q + 16'd1;
            end
          end else begin
            hcount_q <= hcount_q + 16'd1;
          end
        end
        DRAIN: begin
          if (drain_q == DW'(FILL_LATENCY - 1)) begin
            tri_count_q <= tri_count_q + 16'd1;
            // A clear requested during the sweep starts straight away.
            if (clear_pending_q || frame_start) begin
              state_q         <= CLEAR;
              clear_pending_q <= 1'b0;
              clear_color_q   <= clear_color;
              clr_cnt_q       <= '0;
            end else begin
              state_q     <= IDLE;
              tri_ready_q <= 1'b1;
            end
          end else begin
            drain_q    <= drain_q + 1'b1;
            tri_done_q <= (FILL_LATENCY > 1) && (drain_q == DW'(FILL_LATENCY - 2));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic clearing, wr_hit;
  assign clearing = (state_q == CLEAR);
  assign wr_hit   = tag_v_q[FILL_LATENCY-1] & is_within;

  assign pix_we    = clearing | wr_hit;
  assign pix_addr  = clearing ? clr_cnt_q : (wr_hit ? tag_a_q[FILL_LATENCY-1] : '0);
  assign pix_din   = clearing ? clear_color_q : (wr_hit ? tri_color_q : '0);
  assign tri_ready = tri_ready_q;
  assign tri_load  = tri_load_q;
  assign tri_done  = tri_done_q;
  assign tri_count = tri_count_q;
  assign hcount    = hcount_q;
  assign vcount    = vcount_q;
  assign busy      = (state_q != IDLE) | clear_pending_q;

endmodule

// File: tb/tb_raster_fill_sequencer.sv
// Scoreboard bench for raster_fill_sequencer on an 8x4 frame with a mask-driven fill-unit model.
module tb_raster_fill_sequencer;
  localparam int W = 8, H = 4, AB = 5, CW = 16, L = 3;

  logic          clk = 0, rst = 1, frame_start = 0, tri_valid = 0;
  logic [CW-1:0] clear_color = '0, tri_color = '0;
  logic          tri_ready, tri_load, is_within, pix_we, busy, tri_done;
  logic [15:0]   hcount, vcount, tri_count;
  logic [AB-1:0] pix_addr;
  logic [CW-1:0] pix_din;
`ifdef RASTER_FILL_BBOX_CULL_EN
  logic [15:0]   bbox_min_x = 0, bbox_min_y = 0, bbox_max_x = 16'hFFFF, bbox_max_y = 16'hFFFF;
`endif

  raster_fill_sequencer #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .ADDR_BITS(AB),
                          .COLOR_WIDTH(CW), .FILL_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .clear_color(clear_color),
    .tri_valid(tri_valid), .tri_color(tri_color), .tri_ready(tri_ready), .tri_load(tri_load),
    .hcount(hcount), .vcount(vcount), .is_within(is_within), .pix_we(pix_we),
    .pix_addr(pix_addr), .pix_din(pix_din), .busy(busy), .tri_done(tri_done),
`ifdef RASTER_FILL_BBOX_CULL_EN
    .bbox_min_x(bbox_min_x), .bbox_min_y(bbox_min_y),
    .bbox_max_x(bbox_max_x), .bbox_max_y(bbox_max_y),
`endif
    .tri_count(tri_count));

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0;
  logic [31:0] exp_q[$];
  bit [31:0] mask = 0;
  bit p0 = 0, p1 = 0, p2 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic bit inside_f(input logic [15:0] x, input logic [15:0] y);
    int idx;
    if (x >= 16'(W) || y >= 16'(H)) return 1'b0;
    idx = int'(y) * W + int'(x);
    return mask[idx];
  endfunction

  // Fill-unit model: result for a coordinate appears L cycles later.
  always @(posedge clk) begin
    p0 <= inside_f(hcount, vcount);
    p1 <= p0;
    p2 <= p1;
  end
  assign is_within = p2;

  always @(negedge clk) begin
    logic [31:0] e;
    if (pix_we) begin
      check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(pix_addr), 32'(e[31:16]));
        check("wr_data", 32'(pix_din), 32'(e[15:0]));
      end
    end else begin
      check("din_idle", 32'(pix_din), 32'd0);
    end
  end

  task automatic push_wr(input int addr, input logic [15:0] data);
    exp_q.push_back({16'(addr), data});
  endtask

  task automatic push_clear(input logic [15:0] data);
    for (int i = 0; i < W * H; i++) push_wr(i, data);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) begin
      @(posedge clk); #1;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Offers a triangle; fs_at>0 pulses frame_start with clear_color at that sweep cycle.
  task automatic send_tri(input logic [15:0] color, input int exp_lat, input int fs_at);
    int  n;
    bit  got, ready_seen;
    tri_color = color;
    tri_valid = 1;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      if (tri_load) got = 1;
    end
    tri_valid = 0;
    check("tri_load_seen", 32'(got), 32'd1);
    if (!got) return;
    n = 1; ready_seen = 0; got = 0;
    while (n < 200 && !got) begin
      if (n == fs_at) begin
        push_clear(clear_color);
        frame_start = 1;
      end
      @(posedge clk); #1;
      frame_start = 0;
      n++;
      if (tri_ready) ready_seen = 1;
      if (tri_done) got = 1;
    end
    check("tri_done_seen", 32'(got), 32'd1);
    check("tri_latency", 32'(n), 32'(exp_lat));
    check("ready_low_in_sweep", 32'(ready_seen), 32'd0);
    $display("triangle color=%h done after %0d cycles", color, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(tri_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(pix_we), 32'd0);
    check("rst_count", 32'(tri_count), 32'd0);
    check("rst_hcount", 32'(hcount), 32'd0);
    rst = 0;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(tri_ready), 32'd1);

    // Frame clear
    clear_color = 16'h0F0F;
    push_clear(16'h0F0F);
    frame_start = 1;
    @(posedge clk); #1;
    frame_start = 0;
    wait_idle();
    check("clear_drained", 32'(exp_q.size()), 32'd0);
    check("clear_count", 32'(tri_count), 32'd0);
    check("clear_ready", 32'(tri_ready), 32'd1);
    $display("clear color=0f0f complete");

    // Two-pixel triangle
    mask = 32'h0000_0C00;
    push_wr(10, 16'hABCD);
    push_wr(11, 16'hABCD);
    send_tri(16'hABCD, 1 + W * H + L, -1);
    @(posedge clk); #1;
    check("tri1_count", 32'(tri_count), 32'd1);
    check("tri1_drained", 32'(exp_q.size()), 32'd0);

    // Clear and triangle offered together: clear goes first
    clear_color = 16'h1111;
    push_clear(16'h1111);
    push_wr(10, 16'h5A5A);
    push_wr(11, 16'h5A5A);
    frame_start = 1;
    tri_valid = 1;
    tri_color = 16'h5A5A;
    @(posedge clk); #1;
    frame_start = 0;
    send_tri(16'h5A5A, 1 + W * H + L, -1);
    @(posedge clk); #1;
    check("tri2_count", 32'(tri_count), 32'd1);
    check("tri2_drained", 32'(exp_q.size()), 32'd0);

    // Reset during the sweep
    mask = 32'hFFFF_FFFF;
    push_wr(0, 16'hC3C3);
    push_wr(1, 16'hC3C3);
    tri_color = 16'hC3C3;
    tri_valid = 1;
    for (int i = 0; i < 200 && !tri_load; i++) begin
      @(posedge clk); #1;
    end
    tri_valid = 0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("midrst_we", 32'(pix_we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hcount", 32'(hcount), 32'd0);
    check("midrst_count", 32'(tri_count), 32'd0);
    check("midrst_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    check("midrst_ready", 32'(tri_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    $display("reset during sweep recovered");

    // frame_start during the sweep
    mask = 32'h0000_0C00;
    clear_color = 16'h2222;
    push_wr(10, 16'h0707);
    push_wr(11, 16'h0707);
    send_tri(16'h0707, 1 + W * H + L, 10);
    @(posedge clk); #1;
    check("fs_clear_started", 32'(pix_we), 32'd1);
    check("fs_ready_low", 32'(tri_ready), 32'd0);
    wait_idle();
    check("fs_count", 32'(tri_count), 32'd0);
    check("fs_drained", 32'(exp_q.size()), 32'd0);

`ifdef RASTER_FILL_BBOX_CULL_EN
    mask = 32'hFFFF_FFFF;
    bbox_min_x = 2; bbox_min_y = 1; bbox_max_x = 3; bbox_max_y = 2;
    push_wr(10, 16'h1234); push_wr(11, 16'h1234);
    push_wr(18, 16'h1234); push_wr(19, 16'h1234);
    send_tri(16'h1234, 1 + 4 + L, -1);
    @(posedge clk); #1;
    check("bbox_count", 32'(tri_count), 32'd1);
    check("bbox_drained", 32'(exp_q.size()), 32'd0);

    bbox_min_x = 6; bbox_min_y = 3; bbox_max_x = 100; bbox_max_y = 100;
    push_wr(30, 16'h4321); push_wr(31, 16'h4321);
    send_tri(16'h4321, 1 + 2 + L, -1);
    @(posedge clk); #1;
    check("clamp_count", 32'(tri_count), 32'd2);
    check("clamp_drained", 32'(exp_q.size()), 32'd0);

    bbox_min_x = 5; bbox_min_y = 0; bbox_max_x = 2; bbox_max_y = 3;
    send_tri(16'h9999, 1 + L, -1);
    @(posedge clk); #1;
    check("empty_count", 32'(tri_count), 32'd3);
    check("empty_drained", 32'(exp_q.size()), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
